// File: rtl/demux_1to4_stream.sv
// ============================================================================
// Module   : demux_1to4_stream
// Brief    : Registered 1-to-4 stream demultiplexer with a one-entry holding
//            stage. Optional per-lane delivery counters via DEMUX_1TO4_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       selection,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DEMUX_1TO4_COUNT_EN
    ,
    input  logic             cnt_clear,
    output logic [31:0]      lane_count
`endif
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_sel;

    logic             w_accept;
    logic             w_deliver;
    logic             w_sel_ready;
    logic [0:0]       w_state_nxt;

    // Only the selected lane's ready matters; others are ignored by design.
    assign w_sel_ready = out_ready[r_sel];
    assign in_ready    = (r_state == c_EMPTY) || w_sel_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_deliver   = (r_state == c_FULL) && w_sel_ready;
    assign out_data    = r_data;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = c_FULL;
        end else if (w_deliver) begin
            w_state_nxt = c_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
            r_data  <= '0;
            r_sel   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= in_data;
                r_sel  <= selection;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign out_valid[gi] = (r_state == c_FULL) && (r_sel == 2'(gi));

`ifdef DEMUX_1TO4_COUNT_EN
            logic [7:0] r_cnt;

            // Clear wins over a same-edge delivery; counts saturate at 8'hFF.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= 8'h00;
                end else if (cnt_clear) begin
                    r_cnt <= 8'h00;
                end else if (out_valid[gi] && out_ready[gi] && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'h01;
                end
            end

            assign lane_count[8*gi +: 8] = r_cnt;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: vector table plus directed
// reset and counter sequences.
`default_nettype none

module tb_demux_1to4_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] selection;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
`ifdef DEMUX_1TO4_COUNT_EN
    logic        cnt_clear;
    logic [31:0] lane_count;
`endif

    int checks   = 0;
    int failures = 0;

    demux_1to4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .selection (selection),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_1TO4_COUNT_EN
        ,
        .cnt_clear (cnt_clear),
        .lane_count(lane_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic [3:0] exp_ov;
        logic [7:0] exp_od;
        logic       exp_ir;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: inputs driven this cycle, outputs expected before the next edge.
        // Streaming to all four lanes
        vecs[0]  = '{1'b1, 2'd0, 8'h01, 4'hF, 4'b0000, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 2'd1, 8'h02, 4'hF, 4'b0001, 8'h01, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 8'h03, 4'hF, 4'b0010, 8'h02, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 8'h04, 4'hF, 4'b0100, 8'h03, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b1000, 8'h04, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b0000, 8'h04, 1'b1};
        // Single route to lane 2
        vecs[6]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 4'b0000, 8'h04, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b0100, 8'hA5, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b0000, 8'hA5, 1'b1};
        // Backpressure on lane 1, then pass-through reload
        vecs[9]  = '{1'b1, 2'd1, 8'h3C, 4'hF, 4'b0000, 8'hA5, 1'b1};
        vecs[10] = '{1'b1, 2'd1, 8'h77, 4'h0, 4'b0010, 8'h3C, 1'b0};
        vecs[11] = '{1'b1, 2'd1, 8'h77, 4'h0, 4'b0010, 8'h3C, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 8'h77, 4'h0, 4'b0010, 8'h3C, 1'b0};
        vecs[13] = '{1'b1, 2'd1, 8'h77, 4'h0, 4'b0010, 8'h3C, 1'b0};
        vecs[14] = '{1'b1, 2'd1, 8'h77, 4'h0, 4'b0010, 8'h3C, 1'b0};
        vecs[15] = '{1'b1, 2'd1, 8'h77, 4'h2, 4'b0010, 8'h3C, 1'b1};
        vecs[16] = '{1'b0, 2'd0, 8'h00, 4'h0, 4'b0010, 8'h77, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b0010, 8'h77, 1'b1};
        vecs[18] = '{1'b0, 2'd0, 8'h00, 4'hF, 4'b0000, 8'h77, 1'b1};
        // Non-selected lane readies are ignored
        vecs[19] = '{1'b1, 2'd3, 8'h5A, 4'h7, 4'b0000, 8'h77, 1'b1};
        vecs[20] = '{1'b0, 2'd0, 8'h00, 4'h7, 4'b1000, 8'h5A, 1'b0};
        vecs[21] = '{1'b0, 2'd0, 8'h00, 4'h7, 4'b1000, 8'h5A, 1'b0};
        vecs[22] = '{1'b0, 2'd0, 8'h00, 4'h8, 4'b1000, 8'h5A, 1'b1};
        vecs[23] = '{1'b0, 2'd0, 8'h00, 4'h0, 4'b0000, 8'h5A, 1'b1};
        // Data without in_valid is never captured
        vecs[24] = '{1'b0, 2'd1, 8'hFF, 4'hF, 4'b0000, 8'h5A, 1'b1};
        vecs[25] = '{1'b0, 2'd1, 8'hFF, 4'hF, 4'b0000, 8'h5A, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        selection = 2'd0;
        out_ready = 4'h0;
`ifdef DEMUX_1TO4_COUNT_EN
        cnt_clear = 1'b0;
`endif
        #12 rst_n = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data",  32'(out_data),  32'h0);
        check("reset_in_ready",  32'(in_ready),  32'h1);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            selection = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].exp_od));
            check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ir));
        end

        // Asynchronous reset while a word is held
        @(negedge clk);
        in_valid = 1'b1; selection = 2'd0; in_data = 8'h99; out_ready = 4'h0;
        @(negedge clk);
        in_valid = 1'b0;
        check("held_out_valid", 32'(out_valid), 32'h1);
        check("held_out_data",  32'(out_data),  32'h99);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_out_data",  32'(out_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'hF;
        #1;
        check("post_rst_in_ready", 32'(in_ready),  32'h1);
        @(negedge clk);
        check("post_rst_not_delivered", 32'(out_valid), 32'h0);

`ifdef DEMUX_1TO4_COUNT_EN
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("cnt_pre_clear", lane_count, 32'h0);
        for (int i = 0; i < 302; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 8'(i);
            selection = (i < 300) ? 2'd0 : 2'd2;
            out_ready = 4'hF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("cnt_lane0_sat", 32'(lane_count[7:0]),   32'hFF);
        check("cnt_lane1",     32'(lane_count[15:8]),  32'h00);
        check("cnt_lane2",     32'(lane_count[23:16]), 32'h02);
        check("cnt_lane3",     32'(lane_count[31:24]), 32'h00);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("cnt_cleared", lane_count, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
